// File: rtl/raptor64_mult_sched.sv
// Two-requester scheduler for one shared 64-bit multiplier (round-robin grant).
// Optional WAIT-state abort is compiled in with RAPTOR64_MULT_SCHED_TIMEOUT_EN.
module raptor64_mult_sched #(
   parameter logic [7:0] TIMEOUT = 8'd15
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0,
   input  logic         req1,
   input  logic         sgn0,
   input  logic         sgn1,
   input  logic         isMuli0,
   input  logic         isMuli1,
   input  logic [63:0]  a0,
   input  logic [63:0]  a1,
   input  logic [63:0]  b0,
   input  logic [63:0]  b1,
   input  logic [63:0]  imm0,
   input  logic [63:0]  imm1,
   output logic         ack0,
   output logic         ack1,
   output logic         m_ld,
   output logic         m_sgn,
   output logic         m_isMuli,
   output logic [63:0]  m_a,
   output logic [63:0]  m_b,
   output logic [63:0]  m_imm,
   input  logic [127:0] m_o,
   input  logic         m_done,
   output logic [127:0] res,
   output logic         res_vld,
   output logic         res_id,
   output logic         res_err
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_t;

   state_t state;
   state_t state_nx;

   logic owner;
   logic prio;
   logic grant;
   logic any_req;
   logic to_hit;
   logic finish;

   // prio names the requester that wins a tie
   always_comb begin
      any_req = req0 | req1;
      grant   = req1;
      if (req0 && req1)
         grant = prio;
   end

`ifdef RAPTOR64_MULT_SCHED_TIMEOUT_EN
   logic [7:0] tcnt;

   assign to_hit = (tcnt == TIMEOUT - 8'd1);

   always_ff @(posedge clk) begin
      if (!rst)
         tcnt <= 8'd0;
      else if (state == WAIT && !m_done && !to_hit)
         tcnt <= tcnt + 8'd1;
      else
         tcnt <= 8'd0;
   end

   // m_done wins over a coinciding timeout
   always_ff @(posedge clk) begin
      if (!rst)
         res_err <= 1'b0;
      else if (state == WAIT && finish)
         res_err <= !m_done;
   end
`else
   logic unused_cfg;

   assign unused_cfg = ^TIMEOUT;
   assign to_hit     = 1'b0;
   assign res_err    = 1'b0;
`endif

   assign finish = m_done | to_hit;

   always_ff @(posedge clk) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (any_req) state_nx = ISSUE;
         ISSUE:   state_nx = WAIT;
         WAIT:    if (finish) state_nx = RESP;
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign ack0    = (state == ISSUE) && !owner;
   assign ack1    = (state == ISSUE) && owner;
   assign m_ld    = (state == ISSUE);
   assign res_vld = (state == RESP);

   // operands only reload on a grant, so they hold through ISSUE/WAIT
   always_ff @(posedge clk) begin
      if (!rst) begin
         owner    <= 1'b0;
         prio     <= 1'b0;
         m_sgn    <= 1'b0;
         m_isMuli <= 1'b0;
         m_a      <= 64'd0;
         m_b      <= 64'd0;
         m_imm    <= 64'd0;
         res      <= 128'd0;
         res_id   <= 1'b0;
      end else begin
         if (state == IDLE && any_req) begin
            owner    <= grant;
            prio     <= ~grant;
            m_sgn    <= grant ? sgn1 : sgn0;
            m_isMuli <= grant ? isMuli1 : isMuli0;
            m_a      <= grant ? a1 : a0;
            m_b      <= grant ? b1 : b0;
            m_imm    <= grant ? imm1 : imm0;
         end
         if (state == WAIT && finish) begin
            res    <= m_done ? m_o : 128'd0;
            res_id <= owner;
         end
      end
   end

endmodule

// File: tb/tb_raptor64_mult_sched.sv
// Bench for raptor64_mult_sched: directed cases plus random contention
// against a round-robin/product model, with a 6-cycle multiplier stub.
module tb_raptor64_mult_sched;

   logic         clk = 1'b0;
   logic         rst;
   logic         req0, req1, sgn0, sgn1, isMuli0, isMuli1;
   logic [63:0]  a0, a1, b0, b1, imm0, imm1;
   logic         ack0, ack1, m_ld, m_sgn, m_isMuli;
   logic [63:0]  m_a, m_b, m_imm;
   logic [127:0] m_o;
   logic         m_done;
   logic [127:0] res;
   logic         res_vld, res_id, res_err;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   raptor64_mult_sched dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1),
      .sgn0(sgn0), .sgn1(sgn1),
      .isMuli0(isMuli0), .isMuli1(isMuli1),
      .a0(a0), .a1(a1), .b0(b0), .b1(b1),
      .imm0(imm0), .imm1(imm1),
      .ack0(ack0), .ack1(ack1),
      .m_ld(m_ld), .m_sgn(m_sgn), .m_isMuli(m_isMuli),
      .m_a(m_a), .m_b(m_b), .m_imm(m_imm),
      .m_o(m_o), .m_done(m_done),
      .res(res), .res_vld(res_vld),
      .res_id(res_id), .res_err(res_err)
   );

   function automatic logic [127:0] mul_ref(input logic s,
                                            input logic [63:0] x,
                                            input logic [63:0] y);
      logic signed [127:0] sx, sy;
      if (s) begin
         sx = $signed(x);
         sy = $signed(y);
         return sx * sy;
      end
      return {64'd0, x} * {64'd0, y};
   endfunction

   // multiplier stub: m_done pulses six cycles after the m_ld cycle
   logic         stub_en = 1'b1;
   logic [2:0]   scnt = 3'd0;
   logic [127:0] sprod = 128'd0;

   always @(posedge clk) begin
      if (m_ld) begin
         scnt  <= 3'd6;
         sprod <= mul_ref(m_sgn, m_a, m_isMuli ? m_imm : m_b);
      end else if (scnt != 3'd0) begin
         scnt <= scnt - 3'd1;
      end
   end

   assign m_done = stub_en && (scnt == 3'd1);
   assign m_o    = sprod;

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // reqs are already driven for the coming edge; w is the expected winner
   task automatic run_op(input logic w, input logic [127:0] exp_res,
                         input logic exp_err, input int exp_lat,
                         input logic [63:0] exp_a, input string tag);
      int lat;
      int spur;
      logic [63:0] ha, hb, hi;
      @(posedge clk); #1;
      chk({tag, ".ack_w"}, 128'(w ? ack1 : ack0), 128'(1));
      chk({tag, ".ack_l"}, 128'(w ? ack0 : ack1), 128'(0));
      chk({tag, ".m_ld"}, 128'(m_ld), 128'(1));
      chk({tag, ".m_a"}, 128'(m_a), 128'(exp_a));
      ha = m_a; hb = m_b; hi = m_imm;
      if (w) req1 = 1'b0;
      else   req0 = 1'b0;
      lat  = 0;
      spur = 0;
      for (int k = 2; k <= 40 && lat == 0; k++) begin
         @(posedge clk); #1;
         if (ack0 || ack1 || m_ld) spur++;
         if (m_a !== ha || m_b !== hb || m_imm !== hi) spur++;
         if (res_vld) lat = k;
      end
      chk({tag, ".lat"}, 128'(lat), 128'(exp_lat));
      chk({tag, ".spur"}, 128'(spur), 128'(0));
      chk({tag, ".res"}, res, exp_res);
      chk({tag, ".id"}, 128'(res_id), 128'(w));
      chk({tag, ".err"}, 128'(res_err), 128'(exp_err));
      @(posedge clk); #1;
      chk({tag, ".vld1"}, 128'(res_vld), 128'(0));
      chk({tag, ".hold"}, res, exp_res);
   endtask

   logic        pend [2];
   logic        ps [2], pm [2];
   logic [63:0] pa [2], pb [2], pi [2];
   logic        last;
   logic        w;
   logic [127:0] m21;
   int          cnt;

   task automatic new_op(input int r);
      pend[r] = 1'b1;
      ps[r] = 1'($urandom_range(0, 1));
      pm[r] = 1'($urandom_range(0, 1));
      pa[r] = $urandom_range(0, 1) ? {$urandom, $urandom}
                                   : 64'($signed($urandom_range(0, 2000)) - 1000);
      pb[r] = {$urandom, $urandom};
      pi[r] = 64'($signed($urandom_range(0, 600)) - 300);
   endtask

   task automatic drive_pend();
      req0 = pend[0]; sgn0 = ps[0]; isMuli0 = pm[0];
      a0 = pa[0]; b0 = pb[0]; imm0 = pi[0];
      req1 = pend[1]; sgn1 = ps[1]; isMuli1 = pm[1];
      a1 = pa[1]; b1 = pb[1]; imm1 = pi[1];
   endtask

   initial begin
      rst = 1'b0;
      req0 = 0; req1 = 0; sgn0 = 0; sgn1 = 0; isMuli0 = 0; isMuli1 = 0;
      a0 = 0; a1 = 0; b0 = 0; b1 = 0; imm0 = 0; imm1 = 0;
      m21 = 128'd0 - 128'd21;
      repeat (3) @(posedge clk);
      #1;
      chk("rst.ack0", 128'(ack0), 128'(0));
      chk("rst.ack1", 128'(ack1), 128'(0));
      chk("rst.m_ld", 128'(m_ld), 128'(0));
      chk("rst.vld", 128'(res_vld), 128'(0));
      chk("rst.err", 128'(res_err), 128'(0));
      chk("rst.res", res, 128'd0);
      chk("rst.id", 128'(res_id), 128'(0));
      chk("rst.m_ops", {m_a, m_b | m_imm}, 128'd0);
      chk("rst.m_flags", 128'({m_sgn, m_isMuli}), 128'(0));
      rst = 1'b1;
      @(posedge clk); #1;
      last = 1'b1;

      // contention straight after reset: 0 first, then pending 1
      req0 = 1; sgn0 = 0; a0 = 64'd7; b0 = 64'd9;
      req1 = 1; sgn1 = 0; a1 = 64'd11; b1 = 64'd13;
      run_op(1'b0, 128'd63, 1'b0, 8, 64'd7, "cont0");
      run_op(1'b1, 128'd143, 1'b0, 8, 64'd11, "cont1");
      last = 1'b1;

      req0 = 1; sgn0 = 1; isMuli0 = 0; a0 = 64'd10005; b0 = 64'd1117;
      run_op(1'b0, 128'd11175585, 1'b0, 8, 64'd10005, "r027");
      last = 1'b0;

      req1 = 1; sgn1 = 1; isMuli1 = 1;
      a1 = 64'd0 - 64'd3; imm1 = 64'd7; b1 = 64'd99;
      run_op(1'b1, m21, 1'b0, 8, 64'd0 - 64'd3, "r028");
      last = 1'b1;

      pend[0] = 1'b0;
      pend[1] = 1'b0;
      for (int i = 0; i < 24; i++) begin
         for (int r = 0; r < 2; r++)
            if (!pend[r] && $urandom_range(0, 1) == 1) new_op(r);
         if (!pend[0] && !pend[1]) new_op(int'($urandom_range(0, 1)));
         drive_pend();
         w = (pend[0] && pend[1]) ? ~last : pend[1];
         last = w;
         run_op(w, mul_ref(ps[w], pa[w], pm[w] ? pi[w] : pb[w]),
                1'b0, 8, pa[w], "rand");
         pend[w] = 1'b0;
      end
      req0 = 0; req1 = 0;
      if (pend[0] || pend[1]) begin
         w = pend[1];
         drive_pend();
         run_op(w, mul_ref(ps[w], pa[w], pm[w] ? pi[w] : pb[w]),
                1'b0, 8, pa[w], "drain");
      end

      // reset during WAIT; the stub's late m_done lands in IDLE
      req0 = 1; sgn0 = 0; isMuli0 = 0; a0 = 64'd40; b0 = 64'd50;
      @(posedge clk); #1;
      chk("rwait.ack", 128'(ack0), 128'(1));
      req0 = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      chk("rwait.res0", res, 128'd0);
      cnt = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (res_vld || ack0 || ack1) cnt++;
      end
      chk("rwait.quiet", 128'(cnt), 128'(0));
      req0 = 1; sgn0 = 0; a0 = 64'd2; b0 = 64'd3;
      run_op(1'b0, 128'd6, 1'b0, 8, 64'd2, "r030");

      stub_en = 1'b0;
`ifdef RAPTOR64_MULT_SCHED_TIMEOUT_EN
      req0 = 1; sgn0 = 0; a0 = 64'd5; b0 = 64'd5;
      run_op(1'b0, 128'd0, 1'b1, 17, 64'd5, "tmo");
`else
      req0 = 1; sgn0 = 0; a0 = 64'd5; b0 = 64'd5;
      @(posedge clk); #1;
      chk("hang.ack", 128'(ack0), 128'(1));
      req0 = 0;
      cnt = 0;
      for (int k = 0; k < 100; k++) begin
         @(posedge clk); #1;
         if (res_vld) cnt++;
      end
      chk("hang.novld", 128'(cnt), 128'(0));
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
